multi_box_controller: RTL and testbench
=======================================

Name: multi_box_controller

Overview:
- Parametrised successor to the single-box controller in the IR/VGA design.
- Holds N_BOXES independent boxes. The IR direction inputs move only the currently selected box, once per video frame. An edge on sel cycles the selection.
- Resolves per-pixel box coverage and colour for the Drawer, with registered output.
- Sits between the ir block, the XYCounter and the Drawer.

Parameters:
- N_BOXES, 4, number of boxes (1..8).
- COORD_W, 10, width of x/y/position fields.
- H_RES, 640, visible width in pixels.
- V_RES, 480, visible height in pixels.
- BOX_SIZE, 32, edge length of every box in pixels.
- STEP, 4, pixels moved per frame while a direction is held.
- WRAP, 0, edge mode: 0 = clamp at screen edge, 1 = wrap to the opposite edge.

Ports:
- clk  in  1  system clock (full-rate).
- rst_n  in  1  asynchronous active-low reset.
- vs  in  1  vertical sync from XYCounter, active low, asynchronous to clk.
- dir_x  in  2  00/11 = hold, 01 = +x, 10 = -x.
- dir_y  in  2  00/11 = hold, 01 = +y, 10 = -y.
- sel  in  1  level from IR decoder; each rising edge selects the next box.
- x  in  COORD_W  current pixel x.
- y  in  COORD_W  current pixel y.
- active_idx  out  3  index of the selected box.
- frame_tick  out  1  one-clk pulse when a frame update is applied.
- pix_hit  out  1  registered: pixel (x,y) lies inside some box.
- pix_r  out  4  registered colour of the winning box, 0 when no hit.
- pix_g  out  4  same as pix_r.
- pix_b  out  4  same as pix_r.

Behaviour:
- Reset (async, rst_n=0):
  - box i position = (i*(BOX_SIZE+8), 0).
  - active_idx=0, frame_tick=0, pix_hit=0, pix_r/g/b=0, FSM=WAIT_VS.
  - Elaboration check: N_BOXES*(BOX_SIZE+8) <= H_RES.
- Input synchronisation:
  - vs and sel each pass through a 2-FF synchroniser, then a rising/falling-edge detector.
  - Falling edge of synchronised vs = vs_fall.
- FSM:
  - WAIT_VS: on vs_fall, go to CALC.
  - CALC: compute next x/y for active box into next_x/next_y; go to APPLY.
  - APPLY: write next_x/next_y, pulse frame_tick for 1 clk; go to WAIT_VS.
  - A vs_fall occurring outside WAIT_VS is ignored.
- Move arithmetic: computed in COORD_W+1 signed bits, limit LIM_X = H_RES-BOX_SIZE (likewise LIM_Y with V_RES).
  - Clamp (WRAP=0): result < 0 gives 0; result > LIM_X gives LIM_X.
  - Wrap (WRAP=1): result < 0 gives LIM_X; result > LIM_X gives 0.
  - Axes are independent; both may move in the same frame.
- Selection:
  - A sel rising edge sets active_idx = (active_idx+1) mod N_BOXES; N_BOXES-1 goes to 0.
  - If the edge lands in CALC or APPLY, the pending move still targets the box latched on entry to CALC. The new selection applies from the next frame.
- Pixel resolve:
  - Box i is hit if box_x[i] <= x < box_x[i]+BOX_SIZE and likewise for y.
  - The lowest index wins on overlap.
  - Colour comes from the package palette entry [i].
  - Outputs are registered: 1-clk latency from x/y to pix_*.
- Reset mid-frame: immediate return to reset state; no partial move survives.

Optional Feature:
- Macro MBOX_HIGHLIGHT_EN.
- Defined: a pixel inside the active box and within 2 px of its edge outputs pix_hit=1, colour 4'hF/4'hF/4'hF. This overrides the palette and index priority.
- Undefined: no highlight, plain palette colours only.

Decomposition:
- Package mbox_pkg:
  - dir_t enum (HOLD, POS, NEG).
  - fsm_t enum (WAIT_VS, CALC, APPLY).
  - PALETTE[8] of 12-bit RGB constants.
  - Highlight width constant = 2.
- Sub-module box_hit_test (one instance per box, generate loop): combinational compare of x/y against position and BOX_SIZE, outputs hit.

Test Plan:
1. Reset, then pixel (0,0) and (40,0) → pix_hit=1 one clk later, colour PALETTE[0] and PALETTE[1]; (39,0) → pix_hit=0.
2. dir_x=01 held for 10 vs_fall events → box0 x=40; frame_tick pulses exactly 10 times.
3. WRAP=0, box0 at x=0, dir_x=10 for 3 frames → x stays 0. WRAP=1, same stimulus → x=608, 604, 600.
4. Four sel edges with N_BOXES=4 → active_idx 1,2,3,0. A sel edge during CALC → the move still applies to the old box.
5. Move box1 onto box0 → overlapping pixel reports PALETTE[0]. With MBOX_HIGHLIGHT_EN and box1 active → its edge pixels are 4'hF white.
6. Assert rst_n during APPLY → positions return to init and frame_tick=0 immediately.

Source files
------------

// File: rtl/mbox_pkg.sv
// Shared types, palette and helpers for multi_box_controller.
package mbox_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        POS  = 2'b01,
        NEG  = 2'b10
    } dir_t;

    typedef enum logic [1:0] {
        WAIT_VS = 2'b00,
        CALC    = 2'b01,
        APPLY   = 2'b10
    } fsm_t;

    localparam int unsigned HL_W = 2;

    // 12-bit RGB, {r[3:0], g[3:0], b[3:0]}; white is reserved for the highlight
    localparam logic [11:0] PALETTE [8] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
        12'hF0F, 12'h0FF, 12'hF80, 12'h888
    };

    // 00 and 11 both mean hold
    function automatic dir_t decode_dir(input logic [1:0] d);
        case (d)
            2'b01:   return POS;
            2'b10:   return NEG;
            default: return HOLD;
        endcase
    endfunction

endpackage

// File: rtl/multi_box_controller_if.sv
// Pixel bus between the XYCounter/Drawer side (master) and the box controller (slave).
interface multi_box_controller_if #(
    parameter int unsigned COORD_W = 10
) ();
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               pix_hit;
    logic [3:0]         pix_r;
    logic [3:0]         pix_g;
    logic [3:0]         pix_b;

    modport master (output x, y, input pix_hit, pix_r, pix_g, pix_b);
    modport slave  (input x, y, output pix_hit, pix_r, pix_g, pix_b);
endinterface

// File: rtl/box_hit_test.sv
// Combinational test of whether pixel (x,y) lies inside one square box.
module box_hit_test #(
    parameter int unsigned COORD_W  = 10,
    parameter int unsigned BOX_SIZE = 32
) (
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic [COORD_W-1:0] box_x_i,
    input  logic [COORD_W-1:0] box_y_i,
    output logic               hit_o
);
    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;

    // One extra bit so the exclusive end never wraps
    assign x_end = {1'b0, box_x_i} + (COORD_W + 1)'(BOX_SIZE);
    assign y_end = {1'b0, box_y_i} + (COORD_W + 1)'(BOX_SIZE);

    assign hit_o = (x_i >= box_x_i) && ({1'b0, x_i} < x_end) &&
                   (y_i >= box_y_i) && ({1'b0, y_i} < y_end);
endmodule

// File: rtl/multi_box_controller.sv
// N independent IR-steered boxes with per-frame movement and registered pixel resolve.
// Optional macro MBOX_HIGHLIGHT_EN: white 2-px border on the active box.
module multi_box_controller
    import mbox_pkg::*;
#(
    parameter int unsigned N_BOXES  = 4,
    parameter int unsigned COORD_W  = 10,
    parameter int unsigned H_RES    = 640,
    parameter int unsigned V_RES    = 480,
    parameter int unsigned BOX_SIZE = 32,
    parameter int unsigned STEP     = 4,
    parameter int unsigned WRAP     = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vs,
    input  logic [1:0] dir_x,
    input  logic [1:0] dir_y,
    input  logic       sel,
    output logic [2:0] active_idx,
    output logic       frame_tick,
    multi_box_controller_if.slave pix
);
    typedef logic signed [COORD_W:0] scoord_t;

    localparam scoord_t LIM_X = scoord_t'(H_RES - BOX_SIZE);
    localparam scoord_t LIM_Y = scoord_t'(V_RES - BOX_SIZE);

    if (N_BOXES < 1 || N_BOXES > 8 || N_BOXES * (BOX_SIZE + 8) > H_RES) begin : g_bad_cfg
        $error("multi_box_controller: N_BOXES must be 1..8 and fit across H_RES");
    end

    // [0],[1] synchroniser stages, [2] previous synchronised value for edge detect
    logic [2:0] vs_sync_q;
    logic [2:0] sel_sync_q;
    logic       vs_fall;
    logic       sel_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_sync_q  <= '1;
            sel_sync_q <= '0;
        end else begin
            vs_sync_q  <= {vs_sync_q[1:0], vs};
            sel_sync_q <= {sel_sync_q[1:0], sel};
        end
    end

    assign vs_fall  = vs_sync_q[2] & ~vs_sync_q[1];
    assign sel_rise = ~sel_sync_q[2] & sel_sync_q[1];

    fsm_t               state_q, state_d;
    logic [2:0]         active_q;
    logic [2:0]         tgt_q;
    logic [COORD_W-1:0] next_x_q, next_y_q;
    logic [COORD_W-1:0] cur_x, cur_y;
    logic [COORD_W-1:0] box_x_q [N_BOXES];
    logic [COORD_W-1:0] box_y_q [N_BOXES];

    function automatic logic [COORD_W-1:0] move_axis(input logic [COORD_W-1:0] pos,
                                                     input logic [1:0] d,
                                                     input scoord_t lim);
        scoord_t res;
        res = $signed({1'b0, pos});
        case (decode_dir(d))
            POS:     res = res + scoord_t'(STEP);
            NEG:     res = res - scoord_t'(STEP);
            default: res = res;
        endcase
        if (res < 0) begin
            res = (WRAP != 0) ? lim : '0;
        end else if (res > lim) begin
            res = (WRAP != 0) ? '0 : lim;
        end
        return res[COORD_W-1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_VS: if (vs_fall) state_d = CALC;
            CALC:    state_d = APPLY;
            APPLY:   state_d = WAIT_VS;
            default: state_d = WAIT_VS;
        endcase
    end

    always_comb begin
        cur_x = box_x_q[0];
        cur_y = box_y_q[0];
        for (int i = 0; i < int'(N_BOXES); i++) begin
            if (tgt_q == 3'(i)) begin
                cur_x = box_x_q[i];
                cur_y = box_y_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_VS;
            active_q <= '0;
            tgt_q    <= '0;
            next_x_q <= '0;
            next_y_q <= '0;
            for (int i = 0; i < int'(N_BOXES); i++) begin
                box_x_q[i] <= COORD_W'(i * int'(BOX_SIZE + 8));
                box_y_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (sel_rise) begin
                active_q <= (active_q == 3'(N_BOXES - 1)) ? 3'd0 : active_q + 3'd1;
            end
            // Target is frozen here so a selection change mid-update waits a frame
            if (state_q == WAIT_VS && vs_fall) begin
                tgt_q <= active_q;
            end
            if (state_q == CALC) begin
                next_x_q <= move_axis(cur_x, dir_x, LIM_X);
                next_y_q <= move_axis(cur_y, dir_y, LIM_Y);
            end
            if (state_q == APPLY) begin
                for (int i = 0; i < int'(N_BOXES); i++) begin
                    if (tgt_q == 3'(i)) begin
                        box_x_q[i] <= next_x_q;
                        box_y_q[i] <= next_y_q;
                    end
                end
            end
        end
    end

    assign frame_tick = (state_q == APPLY);
    assign active_idx = active_q;

    logic [N_BOXES-1:0] hit;

    for (genvar g = 0; g < int'(N_BOXES); g++) begin : g_box
        box_hit_test #(
            .COORD_W  (COORD_W),
            .BOX_SIZE (BOX_SIZE)
        ) u_hit (
            .x_i     (pix.x),
            .y_i     (pix.y),
            .box_x_i (box_x_q[g]),
            .box_y_i (box_y_q[g]),
            .hit_o   (hit[g])
        );
    end

    logic        hit_d;
    logic [11:0] rgb_d;

    always_comb begin
        hit_d = 1'b0;
        rgb_d = '0;
        // Walk downwards so the lowest index wins on overlap
        for (int i = int'(N_BOXES) - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_d = 1'b1;
                rgb_d = PALETTE[i];
            end
        end
`ifdef MBOX_HIGHLIGHT_EN
        for (int i = 0; i < int'(N_BOXES); i++) begin
            if (active_q == 3'(i) && hit[i]) begin
                if ((pix.x - box_x_q[i]) < COORD_W'(HL_W) ||
                    (box_x_q[i] + COORD_W'(BOX_SIZE - 1) - pix.x) < COORD_W'(HL_W) ||
                    (pix.y - box_y_q[i]) < COORD_W'(HL_W) ||
                    (box_y_q[i] + COORD_W'(BOX_SIZE - 1) - pix.y) < COORD_W'(HL_W)) begin
                    hit_d = 1'b1;
                    rgb_d = 12'hFFF;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix.pix_hit <= 1'b0;
            pix.pix_r   <= '0;
            pix.pix_g   <= '0;
            pix.pix_b   <= '0;
        end else begin
            pix.pix_hit <= hit_d;
            pix.pix_r   <= rgb_d[11:8];
            pix.pix_g   <= rgb_d[7:4];
            pix.pix_b   <= rgb_d[3:0];
        end
    end
endmodule

// File: tb/tb_multi_box_controller.sv
// Directed + randomized bench: clamp and wrap instances driven in lockstep against a box model.
module tb_multi_box_controller;
    import mbox_pkg::*;

    localparam int N    = 4;
    localparam int BS   = 32;
    localparam int STP  = 4;
    localparam int HR   = 640;
    localparam int VR   = 480;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vs;
    logic [1:0] dir_x, dir_y;
    logic       sel;
    logic [2:0] act0, act1;
    logic       ft0, ft1;

    multi_box_controller_if #(.COORD_W(10)) bus0 ();
    multi_box_controller_if #(.COORD_W(10)) bus1 ();

    multi_box_controller #(.N_BOXES(N), .WRAP(0)) u_clamp (
        .clk        (clk),
        .rst_n      (rst_n),
        .vs         (vs),
        .dir_x      (dir_x),
        .dir_y      (dir_y),
        .sel        (sel),
        .active_idx (act0),
        .frame_tick (ft0),
        .pix        (bus0)
    );

    multi_box_controller #(.N_BOXES(N), .WRAP(1)) u_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .vs         (vs),
        .dir_x      (dir_x),
        .dir_y      (dir_y),
        .sel        (sel),
        .active_idx (act1),
        .frame_tick (ft1),
        .pix        (bus1)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int tick_cnt = 0;

    always @(posedge clk) if (ft0) tick_cnt <= tick_cnt + 1;

    // Model: [0] = clamp instance, [1] = wrap instance
    int mx [2][N];
    int my [2][N];
    int active;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < N; i++) begin
                mx[w][i] = i * (BS + 8);
                my[w][i] = 0;
            end
        active = 0;
    endfunction

    function automatic int mv(input int p, input logic [1:0] d, input int lim, input bit wrap);
        int r;
        r = p;
        if (d == 2'b01) r = p + STP;
        else if (d == 2'b10) r = p - STP;
        if (r < 0) r = wrap ? lim : 0;
        else if (r > lim) r = wrap ? 0 : lim;
        return r;
    endfunction

    function automatic logic [12:0] model_pix(input int w, input int px, input int py);
        logic [12:0] r;
        int a;
        r = '0;
        for (int i = N - 1; i >= 0; i--)
            if (px >= mx[w][i] && px < mx[w][i] + BS && py >= my[w][i] && py < my[w][i] + BS)
                r = {1'b1, PALETTE[i]};
`ifdef MBOX_HIGHLIGHT_EN
        a = active;
        if (px >= mx[w][a] && px < mx[w][a] + BS && py >= my[w][a] && py < my[w][a] + BS)
            if (px - mx[w][a] < 2 || mx[w][a] + BS - 1 - px < 2 ||
                py - my[w][a] < 2 || my[w][a] + BS - 1 - py < 2)
                r = {1'b1, 12'hFFF};
`else
        a = 0;
`endif
        return r;
    endfunction

    task automatic probe(input int px, input int py);
        logic [12:0] o0, o1;
        if (px < 0) px = 0;
        if (px > HR - 1) px = HR - 1;
        if (py < 0) py = 0;
        if (py > VR - 1) py = VR - 1;
        @(negedge clk);
        bus0.x = 10'(px); bus0.y = 10'(py);
        bus1.x = 10'(px); bus1.y = 10'(py);
        @(posedge clk); #1;
        o0 = {bus0.pix_hit, bus0.pix_r, bus0.pix_g, bus0.pix_b};
        o1 = {bus1.pix_hit, bus1.pix_r, bus1.pix_g, bus1.pix_b};
        check($sformatf("pix_clamp(%0d,%0d)", px, py), 32'(o0), 32'(model_pix(0, px, py)));
        check($sformatf("pix_wrap(%0d,%0d)", px, py), 32'(o1), 32'(model_pix(1, px, py)));
    endtask

    task automatic frame(input logic [1:0] dx, input logic [1:0] dy, input bit sel_in_calc);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        dir_x = dx; dir_y = dy; vs = 1'b0;
        // One clock later the synchronised sel edge lands while the FSM is in CALC
        if (sel_in_calc) begin @(negedge clk); sel = 1'b1; end
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk); #1;
            if (ft0) seen = 1'b1;
        end
        check("frame_tick_seen", 32'(seen), 32'd1);
        check("frame_tick_wrap_inst", 32'(ft1), 32'(ft0));
        for (int w = 0; w < 2; w++) begin
            mx[w][active] = mv(mx[w][active], dx, HR - BS, w == 1);
            my[w][active] = mv(my[w][active], dy, VR - BS, w == 1);
        end
        if (sel_in_calc) active = (active + 1) % N;
        @(negedge clk);
        vs = 1'b1; sel = 1'b0;
        repeat (5) @(negedge clk);
        if (sel_in_calc) check("active_after_calc_sel", 32'(act0), 32'(active));
    endtask

    task automatic sel_pulse();
        @(negedge clk); sel = 1'b1;
        repeat (4) @(negedge clk);
        sel = 1'b0;
        repeat (4) @(negedge clk);
        active = (active + 1) % N;
        check("active_idx_clamp", 32'(act0), 32'(active));
        check("active_idx_wrap", 32'(act1), 32'(active));
    endtask

    initial begin
        int t0, b, w;
        bit seen;
        rst_n = 1'b0; vs = 1'b1; sel = 1'b0; dir_x = 2'b00; dir_y = 2'b00;
        bus0.x = '0; bus0.y = '0; bus1.x = '0; bus1.y = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_pix", 32'({bus0.pix_hit, bus0.pix_r, bus0.pix_g, bus0.pix_b}), 32'd0);
        check("reset_active", 32'(act0), 32'd0);
        check("reset_tick", 32'({ft0, ft1}), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Initial layout and box boundaries
        probe(0, 0); probe(40, 0); probe(39, 0); probe(31, 31); probe(32, 0);

        // Leftward from x=0: clamp holds at 0, wrap jumps to 608 then steps down
        for (int f = 0; f < 3; f++) begin
            frame(2'b10, 2'b00, 1'b0);
            probe(0, 0); probe(HR - BS, 0); probe(HR - BS - 4 * f - 1, 0);
        end

        // Ten rightward frames, counting frame_tick pulses
        t0 = tick_cnt;
        for (int f = 0; f < 10; f++) frame(2'b01, 2'b00, 1'b0);
        check("tick_count_10", 32'(tick_cnt - t0), 32'd10);
        probe(40, 0); probe(39, 0); probe(71, 0); probe(72, 0); probe(28, 0);

        // Selection cycling, then a sel edge during CALC
        for (int k = 0; k < 4; k++) sel_pulse();
        frame(2'b01, 2'b01, 1'b1);
        probe(44, 4); probe(43, 4); probe(40, 0); probe(40, 3);

        // Box 1 is active and overlaps box 0: overlap shows box 0 except on the highlight
        frame(2'b00, 2'b01, 1'b0);
        probe(50, 10); probe(40, 4); probe(41, 10); probe(71, 35); probe(60, 35); probe(45, 5);

        // Randomized frames and probes near boxes
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 5) == 0) sel_pulse();
            frame(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 7) == 0);
            for (int p = 0; p < 3; p++) begin
                b = $urandom_range(0, N - 1);
                w = $urandom_range(0, 1);
                probe(mx[w][b] + $urandom_range(0, BS + 3) - 2,
                      my[w][b] + $urandom_range(0, BS + 3) - 2);
            end
        end

        // Reset asserted while APPLY is presenting frame_tick
        if (active == 0) sel_pulse();
        @(negedge clk);
        dir_x = 2'b01; dir_y = 2'b01; vs = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk); #1;
            if (ft0) seen = 1'b1;
        end
        check("apply_reached", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_tick_clamp", 32'(ft0), 32'd0);
        check("rst_tick_wrap", 32'(ft1), 32'd0);
        check("rst_active", 32'(act0), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        vs = 1'b1; dir_x = 2'b00; dir_y = 2'b00;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        probe(0, 0); probe(40, 0); probe(39, 0); probe(80, 0); probe(120, 31); probe(152, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
